// File: rtl/uart_pkg.sv
// Shared UART types and helpers: receiver FSM states, data width, bit-period calculation.
package uart_pkg;

  localparam int UART_DATA_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/bit_sync.sv
// Two-flop synchroniser for an asynchronous input pin; RST_VAL sets the value both flops reset to.
module bit_sync #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= RST_VAL;
      r_q    <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 by default, 8E1/8O1 when UART_RX_PARITY_EN is defined.
// Received bytes sit in a one-entry valid/ready holding register; errors are one-cycle pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int   CLK_FREQ   = 100000000,
  parameter int   BAUD_RATE  = 115200,
  parameter logic PARITY_ODD = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   uart_rxd,
  output logic [UART_DATA_W-1:0] uart_rd_data,
  output logic                   uart_rd_valid,
  input  logic                   uart_rd_ready,
  output logic                   frame_err,
  output logic                   overrun_err,
  output logic                   parity_err
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_BIT - 1);

  logic                   w_rx_sync;
  logic                   r_rx_prev;
  logic [1:0]             r_flush;
  rx_state_t              r_state;
  rx_state_t              w_state_nxt;
  logic [CNT_W-1:0]       r_cnt;
  logic [2:0]             r_idx;
  logic [UART_DATA_W-1:0] r_shift;
  logic                   w_fall;
  logic                   w_bit_end;
  logic                   w_half;
  logic                   w_cnt_clr;
  logic                   w_shift_en;
  logic                   w_par_en;
  logic                   w_stop_ok;
  logic                   w_stop_bad;
  logic                   w_par_bad;
  logic                   w_deliver;

  bit_sync #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .i_d  (uart_rxd),
    .o_q  (w_rx_sync)
  );

  // rx_prev is held at 0 until the reset value has drained out of the synchroniser,
  // so a line that is low at reset release never looks like a falling edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_flush   <= 2'b00;
      r_rx_prev <= 1'b0;
    end else begin
      r_flush   <= {r_flush[0], 1'b1};
      r_rx_prev <= r_flush[1] ? w_rx_sync : 1'b0;
    end
  end

  assign w_fall    = r_rx_prev & ~w_rx_sync;
  assign w_bit_end = (r_cnt == CNT_LAST);
  assign w_half    = (r_cnt == CNT_HALF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_clr   = 1'b0;
    w_shift_en  = 1'b0;
    w_par_en    = 1'b0;
    w_stop_ok   = 1'b0;
    w_stop_bad  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_fall) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = START;
        end
      end
      START: begin
        if (w_half) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_sync ? IDLE : DATA;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            w_state_nxt = PARITY;
`else
            w_state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (w_bit_end) begin
          w_cnt_clr   = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (w_bit_end) begin
          w_cnt_clr = 1'b1;
          if (w_rx_sync) begin
            w_stop_ok   = 1'b1;
            w_state_nxt = IDLE;
          end else begin
            w_stop_bad  = 1'b1;
            w_state_nxt = BREAK;
          end
        end
      end
      BREAK: begin
        if (w_rx_sync) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_idx   <= 3'd0;
      r_shift <= '0;
    end else begin
      if (w_cnt_clr || r_state == IDLE || r_state == BREAK) r_cnt <= '0;
      else                                                  r_cnt <= r_cnt + CNT_W'(1);
      if (r_state != DATA) r_idx <= 3'd0;
      else if (w_shift_en) r_idx <= r_idx + 3'd1;
      if (w_shift_en) r_shift <= {w_rx_sync, r_shift[UART_DATA_W-1:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  logic r_par_bad;
  logic r_parity_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      if (r_state == IDLE) r_par_bad <= 1'b0;
      else if (w_par_en)   r_par_bad <= (^r_shift) ^ w_rx_sync ^ PARITY_ODD;
      r_parity_err <= w_stop_ok & r_par_bad;
    end
  end

  assign w_par_bad  = r_par_bad;
  assign parity_err = r_parity_err;
`else
  // Without a parity bit the sense parameter has no effect.
  assign w_par_bad  = 1'b0;
  assign parity_err = PARITY_ODD & 1'b0;
`endif

  assign w_deliver = w_stop_ok & ~w_par_bad;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uart_rd_data  <= '0;
      uart_rd_valid <= 1'b0;
      frame_err     <= 1'b0;
      overrun_err   <= 1'b0;
    end else begin
      frame_err   <= w_stop_bad;
      overrun_err <= 1'b0;
      if (w_deliver) begin
        if (!uart_rd_valid || uart_rd_ready) begin
          uart_rd_data  <= r_shift;
          uart_rd_valid <= 1'b1;
        end else begin
          overrun_err <= 1'b1;
        end
      end else if (uart_rd_valid && uart_rd_ready) begin
        uart_rd_valid <= 1'b0;
      end
    end
  end

endmodule
